// File: rtl/branch_outcome_tracker_if.sv
// branch_outcome_tracker_if: predictor/resolve/update signal bundle for branch_outcome_tracker.
// Stats signals exist only when BOT_STATS_EN is defined.
interface branch_outcome_tracker_if #(parameter int PTR_W = 2);
  logic pred_valid;
  logic pred_taken;
  logic pred_ready;
  logic resolve_valid;
  logic resolve_taken;
  logic upd_result;
  logic upd_taken;
  logic mispredict;
  logic [PTR_W:0] count;
  logic err_overflow;
  logic err_underflow;
`ifdef BOT_STATS_EN
  logic [15:0] stat_resolved;
  logic [15:0] stat_mispred;
  modport master (
    output pred_valid, pred_taken, resolve_valid, resolve_taken,
    input pred_ready, upd_result, upd_taken, mispredict, count, err_overflow, err_underflow,
    input stat_resolved, stat_mispred
  );
  modport slave (
    input pred_valid, pred_taken, resolve_valid, resolve_taken,
    output pred_ready, upd_result, upd_taken, mispredict, count, err_overflow, err_underflow,
    output stat_resolved, stat_mispred
  );
`else
  modport master (
    output pred_valid, pred_taken, resolve_valid, resolve_taken,
    input pred_ready, upd_result, upd_taken, mispredict, count, err_overflow, err_underflow
  );
  modport slave (
    input pred_valid, pred_taken, resolve_valid, resolve_taken,
    output pred_ready, upd_result, upd_taken, mispredict, count, err_overflow, err_underflow
  );
`endif
endinterface

// File: rtl/branch_outcome_tracker.sv
// branch_outcome_tracker: in-order queue of predictions that drives predictor counter updates
// and flushes wrong-path entries on mispredict; optional BOT_STATS_EN adds saturating counters.
module branch_outcome_tracker #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input logic clk,
  input logic rst_n,
  branch_outcome_tracker_if.slave bus
);
  localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);
  logic [DEPTH-1:0] mem;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic full, empty, pop, mis, push, ovf, unf;
  always_comb begin
    full = bus.count == FULL;
    empty = bus.count == '0;
    pop = bus.resolve_valid & ~empty;
    mis = pop & (mem[rd_ptr] != bus.resolve_taken);
    // a mispredicting pop discards any same-cycle push as wrong-path
    push = bus.pred_valid & (~full | pop) & ~mis;
    ovf = bus.pred_valid & full & ~pop;
    unf = bus.resolve_valid & empty;
  end
  assign bus.pred_ready = ~full;
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= bus.pred_taken;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      bus.count <= '0;
      bus.upd_result <= 1'b0;
      bus.upd_taken <= 1'b0;
      bus.mispredict <= 1'b0;
      bus.err_overflow <= 1'b0;
      bus.err_underflow <= 1'b0;
    end else begin
      wr_ptr <= push ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr <= mis ? wr_ptr : pop ? rd_ptr + 1'b1 : rd_ptr;
      bus.count <= mis ? '0 : bus.count + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};
      bus.upd_result <= pop;
      bus.upd_taken <= pop ? bus.resolve_taken : bus.upd_taken;
      bus.mispredict <= mis;
      bus.err_overflow <= bus.err_overflow | ovf;
      bus.err_underflow <= bus.err_underflow | unf;
    end
  end
`ifdef BOT_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.stat_resolved <= '0;
      bus.stat_mispred <= '0;
    end else begin
      bus.stat_resolved <= (pop && bus.stat_resolved != 16'hFFFF) ? bus.stat_resolved + 16'd1 : bus.stat_resolved;
      bus.stat_mispred <= (mis && bus.stat_mispred != 16'hFFFF) ? bus.stat_mispred + 16'd1 : bus.stat_mispred;
    end
  end
`endif
endmodule
